// File: rtl/fir_out_shaper_if.sv
// Stream bundle for fir_out_shaper: FIR-side sample strobe and sink-side valid/ready.
interface fir_out_shaper_if #(
  parameter int unsigned DIN_BITS  = 24,
  parameter int unsigned DOUT_BITS = 16
);
  logic [DIN_BITS-1:0]  in_data;
  logic                 in_valid;
  logic [DOUT_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/fir_out_shaper.sv
// FIR output stage: decimate, round/shift, saturate, then buffer in a show-ahead FIFO.
// Define FIR_OUT_CONVERGENT_EN for round-half-to-even instead of round-half-up.
module fir_out_shaper #(
  parameter int unsigned DIN_BITS   = 24,
  parameter int unsigned DOUT_BITS  = 16,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned DECIM      = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  fir_out_shaper_if.slave  bus,
  output logic             sat,
  output logic             overflow
);

  localparam int unsigned CntW = FIFO_AW + 1;
  localparam logic [7:0] DecimLast = 8'(DECIM - 1);
  localparam logic signed [DIN_BITS:0] One = (DIN_BITS + 1)'(1);
  localparam logic signed [DIN_BITS:0] RoundHalf = One <<< (SHIFT - 1);
  localparam logic signed [DIN_BITS:0] SatMax =
      {{(DIN_BITS - DOUT_BITS + 2){1'b0}}, {(DOUT_BITS - 1){1'b1}}};
  localparam logic signed [DIN_BITS:0] SatMin =
      {{(DIN_BITS - DOUT_BITS + 2){1'b1}}, {(DOUT_BITS - 1){1'b0}}};
  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

  logic [7:0]              dcnt_q, dcnt_d;
  logic                    accept;
  logic signed [DIN_BITS:0] ext, summed, shifted, rounded;
  logic [DOUT_BITS-1:0]    clipped;
  logic                    clip;
  logic                    s1_v_q, s1_sat_q;
  logic [DOUT_BITS-1:0]    s1_data_q;
  logic [DOUT_BITS-1:0]    mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q;
  logic                    overflow_q;
  logic                    full, rd_en, wr_en, drop;

  // Decimation: only the sample that arrives with dcnt at zero is kept.
  always_comb begin
    dcnt_d = dcnt_q;
    if (clear) begin
      dcnt_d = '0;
    end else if (bus.in_valid) begin
      dcnt_d = (dcnt_q == DecimLast) ? '0 : dcnt_q + 8'd1;
    end
    accept = bus.in_valid && (dcnt_q == '0);
  end

  always_comb begin
    ext     = {bus.in_data[DIN_BITS-1], bus.in_data};
    summed  = ext + RoundHalf;
    shifted = summed >>> SHIFT;
    rounded = shifted;
`ifdef FIR_OUT_CONVERGENT_EN
    // Exact tie rounded up to an odd value: step back to the even neighbour.
    if ((bus.in_data[SHIFT-1:0] == RoundHalf[SHIFT-1:0]) && shifted[0]) begin
      rounded = shifted - One;
    end
`endif
    clip    = 1'b0;
    clipped = rounded[DOUT_BITS-1:0];
    if (rounded > SatMax) begin
      clip    = 1'b1;
      clipped = SatMax[DOUT_BITS-1:0];
    end else if (rounded < SatMin) begin
      clip    = 1'b1;
      clipped = SatMin[DOUT_BITS-1:0];
    end
  end

  always_comb begin
    full  = (count_q == FullCount);
    rd_en = (count_q != '0) && bus.out_ready;
    wr_en = s1_v_q && (!full || rd_en);
    drop  = s1_v_q && !wr_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_sat_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      s1_v_q <= accept && !clear;
      if (accept) begin
        s1_sat_q  <= clip;
        s1_data_q <= clipped;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_q + CntW'(wr_en) - CntW'(rd_en);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Clear leaves stored words in place; only reset wipes the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en && !clear) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  always_comb begin
    bus.out_data  = mem_q[rd_ptr_q];
    bus.out_valid = (count_q != '0);
    sat           = s1_v_q && s1_sat_q;
    overflow      = overflow_q;
  end

endmodule

// File: tb/tb_fir_out_shaper.sv
// Directed bench for fir_out_shaper: one instance with DECIM=1, one with DECIM=4.
module tb_fir_out_shaper;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic sat1, ovf1, sat4, ovf4;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fir_out_shaper_if #(.DIN_BITS(24), .DOUT_BITS(16)) bus1 ();
  fir_out_shaper_if #(.DIN_BITS(24), .DOUT_BITS(16)) bus4 ();

  fir_out_shaper #(.DECIM(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus1), .sat(sat1), .overflow(ovf1)
  );

  fir_out_shaper #(.DECIM(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus4), .sat(sat4), .overflow(ovf4)
  );

  // Drive one sample on dut1 into an empty FIFO and capture sat and the output word.
  task automatic run_vec(input logic [23:0] d, output logic early_v, output logic s,
                         output logic v, output logic [15:0] q);
    bus1.out_ready = 1'b1;
    bus1.in_data   = d;
    bus1.in_valid  = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    early_v = bus1.out_valid;
    s       = sat1;
    @(negedge clk);
    v = bus1.out_valid;
    q = bus1.out_data;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid got %b want 0", bus1.out_valid); end
    n_cmp++; if (bus1.out_data !== 16'h0000) begin n_bad++; $display("FAIL reset out_data got %h want 0000", bus1.out_data); end
    n_cmp++; if (sat1 !== 1'b0) begin n_bad++; $display("FAIL reset sat got %b want 0", sat1); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL reset overflow got %b want 0", ovf1); end
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid4 got %b want 0", bus4.out_valid); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rounding;
    logic [23:0] din [4];
    logic [15:0] exp_q [4];
    logic early_v, s, v;
    logic [15:0] q;
    din   = '{24'h000180, 24'h000280, 24'hFFFF80, 24'hFFFE80};
`ifdef FIR_OUT_CONVERGENT_EN
    exp_q = '{16'h0002, 16'h0002, 16'h0000, 16'hFFFE};
`else
    exp_q = '{16'h0002, 16'h0003, 16'h0000, 16'hFFFF};
`endif
    for (int i = 0; i < 4; i++) begin
      run_vec(din[i], early_v, s, v, q);
      n_cmp++; if (early_v !== 1'b0) begin n_bad++; $display("FAIL round[%0d] early out_valid got %b want 0", i, early_v); end
      n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL round[%0d] out_valid got %b want 1", i, v); end
      n_cmp++; if (q !== exp_q[i]) begin n_bad++; $display("FAIL round[%0d] out_data got %h want %h", i, q, exp_q[i]); end
      n_cmp++; if (s !== 1'b0) begin n_bad++; $display("FAIL round[%0d] sat got %b want 0", i, s); end
    end
  endtask

  task automatic test_saturation;
    logic [23:0] din [3];
    logic [15:0] exp_q [3];
    logic        exp_s [3];
    logic early_v, s, v;
    logic [15:0] q;
    din   = '{24'h7FFFFF, 24'h800000, 24'h7FFF7F};
    exp_q = '{16'h7FFF, 16'h8000, 16'h7FFF};
    exp_s = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_vec(din[i], early_v, s, v, q);
      n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL sat[%0d] out_valid got %b want 1", i, v); end
      n_cmp++; if (q !== exp_q[i]) begin n_bad++; $display("FAIL sat[%0d] out_data got %h want %h", i, q, exp_q[i]); end
      n_cmp++; if (s !== exp_s[i]) begin n_bad++; $display("FAIL sat[%0d] sat got %b want %b", i, s, exp_s[i]); end
    end
    n_cmp++; if (sat1 !== 1'b0) begin n_bad++; $display("FAIL sat idle pulse got %b want 0", sat1); end
  endtask

  task automatic test_decimation;
    int nout = 0;
    logic [15:0] got [4];
    got = '{16'h0, 16'h0, 16'h0, 16'h0};
    bus4.out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      bus4.in_data  = 24'(k * 256);
      bus4.in_valid = (k <= 8);
      @(negedge clk);
      if (bus4.out_valid) begin
        if (nout < 4) got[nout] = bus4.out_data;
        nout++;
      end
    end
    bus4.in_valid = 1'b0;
    n_cmp++; if (nout !== 2) begin n_bad++; $display("FAIL decim count got %0d want 2", nout); end
    n_cmp++; if (got[0] !== 16'h0001) begin n_bad++; $display("FAIL decim first got %h want 0001", got[0]); end
    n_cmp++; if (got[1] !== 16'h0005) begin n_bad++; $display("FAIL decim second got %h want 0005", got[1]); end
  endtask

  task automatic test_backpressure;
    bus1.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus1.in_data  = 24'(k * 256);
      bus1.in_valid = 1'b1;
      @(negedge clk);
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus1.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp out_valid got %b want 1", bus1.out_valid); end
    n_cmp++; if (ovf1 !== 1'b1) begin n_bad++; $display("FAIL bp overflow got %b want 1", ovf1); end
    bus1.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 16'(k)) begin
        n_bad++; $display("FAIL bp drain[%0d] got v=%b d=%h want v=1 d=%h", k, bus1.out_valid, bus1.out_data, 16'(k));
      end
      @(negedge clk);
    end
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp empty out_valid got %b want 0", bus1.out_valid); end
    n_cmp++; if (ovf1 !== 1'b1) begin n_bad++; $display("FAIL bp sticky overflow got %b want 1", ovf1); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL bp clear overflow got %b want 0", ovf1); end
  endtask

  task automatic test_full_rw;
    bus1.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus1.in_data  = 24'(k * 256);
      bus1.in_valid = 1'b1;
      @(negedge clk);
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    n_cmp++; if (bus1.out_data !== 16'h0001) begin n_bad++; $display("FAIL fullrw head got %h want 0001", bus1.out_data); end
    @(negedge clk);
    bus1.out_ready = 1'b0;
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL fullrw overflow got %b want 0", ovf1); end
    bus1.out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      n_cmp++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 16'(k)) begin
        n_bad++; $display("FAIL fullrw drain[%0d] got v=%b d=%h want v=1 d=%h", k, bus1.out_valid, bus1.out_data, 16'(k));
      end
      @(negedge clk);
    end
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL fullrw empty got %b want 0", bus1.out_valid); end
  endtask

  task automatic test_clear;
    bus4.out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      bus4.in_data  = 24'(k * 256);
      bus4.in_valid = 1'b1;
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'h0001) begin
      n_bad++; $display("FAIL clear pre got v=%b d=%h want v=1 d=0001", bus4.out_valid, bus4.out_data);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL clear out_valid got %b want 0", bus4.out_valid); end
    n_cmp++; if (ovf4 !== 1'b0) begin n_bad++; $display("FAIL clear overflow got %b want 0", ovf4); end
    // With dcnt back at zero the very next strobe must be kept.
    bus4.in_data  = 24'h000B00;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'h000B) begin
      n_bad++; $display("FAIL clear dcnt got v=%b d=%h want v=1 d=000b", bus4.out_valid, bus4.out_data);
    end
    bus4.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    bus1.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus1.in_data  = 24'(k * 256);
      bus1.in_valid = 1'b1;
      @(negedge clk);
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus1.out_valid !== 1'b1) begin n_bad++; $display("FAIL arst pre out_valid got %b want 1", bus1.out_valid); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst out_valid got %b want 0", bus1.out_valid); end
    n_cmp++; if (bus1.out_data !== 16'h0000) begin n_bad++; $display("FAIL arst out_data got %h want 0000", bus1.out_data); end
    @(negedge clk);
    reset = 1'b0;
    bus1.in_data  = 24'h000C00;
    bus1.in_valid = 1'b1;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 16'h000C) begin
      n_bad++; $display("FAIL arst post got v=%b d=%h want v=1 d=000c", bus1.out_valid, bus1.out_data);
    end
    @(negedge clk);
  endtask

  initial begin
    bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus4.in_data = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    test_reset();
    test_rounding();
    test_saturation();
    test_decimation();
    test_backpressure();
    test_full_rw();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_out_shaper.md
Name: fir_out_shaper

Overview:
- Output stage placed directly after the serial FIR core.
- Consumes the core's wide data_out/valid pulse stream, applies optional decimation, rounds and right-shifts, and saturates to the system output width.
- Buffers results in a small FIFO so the sink can apply valid/ready backpressure independently of the FIR sample rate.

Parameters:
- DIN_BITS, 24, width of FIR result (signed two's complement).
- DOUT_BITS, 16, output width (signed); must be < DIN_BITS-SHIFT+1.
- SHIFT, 8, arithmetic right-shift applied before saturation; must be >= 1.
- DECIM, 1, keep 1 of every DECIM input samples; 1..256.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous flush of counter, pipeline, FIFO and overflow.
- in_data  in  DIN_BITS  FIR result; sampled only when in_valid=1.
- in_valid  in  1  single-cycle strobe from the FIR core.
- out_data  out  DOUT_BITS  head-of-FIFO word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts; transfer when out_valid & out_ready.
- sat  out  1  one-cycle pulse, saturation occurred on the sample entering the FIFO.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.

Behaviour:
- Reset values: out_data=0, out_valid=0, sat=0, overflow=0. Decimation counter, pointers, FIFO count and the stage-1 valid flag are all 0; FIFO memory is cleared to 0.
- Decimation counter dcnt, width 8:
  - Increments on each in_valid and wraps DECIM-1 -> 0.
  - A sample is accepted when in_valid=1 and dcnt==0.
  - With DECIM=1 every sample is accepted.
- Stage 1, registered, 1 cycle after acceptance:
  - Sign-extend in_data to DIN_BITS+1.
  - Add 2^(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - Saturate to [-2^(DOUT_BITS-1), 2^(DOUT_BITS-1)-1].
  - The stage-1 valid flag s1_v is set for one cycle; s1_sat records whether clipping occurred.
- FIFO write:
  - When s1_v=1, the word is written if the FIFO is not full, or if a read occurs in the same cycle (simultaneous read+write at full is accepted and count is unchanged).
  - Otherwise the word is dropped and overflow is set.
  - sat pulses in the s1_v cycle when s1_sat=1, whether or not the word is dropped.
- FIFO read:
  - Show-ahead. out_data = mem[rd_ptr]; out_valid = (count != 0).
  - Pointers wrap modulo FIFO_DEPTH.
  - Read while empty is impossible because out_valid=0.
- Latency: in_valid at cycle N gives s1_v at N+1, FIFO write at the N+1 edge, and out_valid=1 at N+2 when the FIFO was empty.
- Back-to-back in_valid every cycle is supported; throughput is 1 sample/cycle.
- clear:
  - Takes priority over all same-cycle writes and reads.
  - Next cycle: count=0, out_valid=0, dcnt=0, s1_v=0, overflow=0. Memory contents are unchanged.
- overflow clears only on reset or clear.
- Reset asserted mid-operation: all state returns to the reset values immediately, asynchronously. The first accepted sample after release is the first in_valid with dcnt==0.

Optional Feature:
- Macro FIR_OUT_CONVERGENT_EN.
- Defined: round half to even. An exact .5 fraction (dropped bits == 2^(SHIFT-1)) rounds toward the even result; all other cases are identical to round half up. Saturation is unchanged.
- Undefined: round half up as described above.
- Latency is identical in both builds.

Test Plan:
- Rounding, defaults: in_data=0x000180 (1.5) -> out_data=0x0002 at N+2. in_data=0x000280 (2.5) -> 0x0003; with FIR_OUT_CONVERGENT_EN -> 0x0002. in_data=0xFFFF80 (-0.5) -> 0x0000.
- Saturation: in_data=0x7FFFFF -> out_data=0x7FFF and sat pulse. in_data=0x800000 -> 0x8000 with no sat. in_data=0x7FFF7F -> 0x7FFF with no sat.
- Decimation, DECIM=4: eight in_valid pulses with values k*256, k=1..8 -> exactly two outputs, 0x0001 then 0x0005.
- Backpressure, out_ready=0: six samples 1..6 (x256) -> FIFO holds 1..4, overflow=1, out_valid=1. Then out_ready=1 -> outputs 1,2,3,4 in consecutive cycles, then out_valid=0, overflow still 1.
- Full plus simultaneous read/write: FIFO full, out_ready=1 in the same cycle s1_v=1 -> no drop, overflow stays 0, new word appears after the existing three.
- Reset and clear mid-operation: with 3 entries and dcnt=2, pulse clear -> out_valid=0 next cycle, dcnt=0, overflow=0. Repeat with async reset asserted between edges -> out_valid falls before the next edge.
